// File: rtl/pwm_ramp_scheduler.sv
//------------------------------------------------------------------------------
// pwm_ramp_scheduler
//
// Purpose:
//   Produces the 17-bit PWM control word (PWM_CW) that feeds the PWM
//   controller. Target duty commands arrive over a valid/ready handshake and
//   are clamped into [MIN_CW, MAX_CW]. The control word then walks toward the
//   target by a programmable step, once per PWM period, which limits how fast
//   a servo or actuator can be driven.
//
//   The control word only ever changes on the last cycle of a PWM period, so
//   the PWM controller never sees a duty change in the middle of a period.
//
// Optional feature (compile-time macro PWM_SCHED_AUTO_PARK_EN):
//   When defined, an idle counter counts whole PWM periods spent in IDLE.
//   After IDLE_TIMEOUT of them the scheduler launches its own ramp toward
//   PARK_CW with step PARK_STEP. That ramp behaves exactly like a commanded
//   ramp (handshake held off, busy high, abortable, ramp_done at the end).
//   When undefined, pwm_cw holds its value indefinitely while idle and the
//   IDLE_TIMEOUT / PARK_CW / PARK_STEP parameters have no effect.
//
// Parameters:
//   PERIOD       PWM period in clk cycles (>= 2), equal to the PWM counter wrap
//   MIN_CW       lowest legal control word
//   MAX_CW       highest legal control word (MIN_CW <= MAX_CW)
//   RESET_CW     control word loaded at reset, inside [MIN_CW, MAX_CW]
//   IDLE_TIMEOUT idle periods before auto-park (optional feature only)
//   PARK_CW      auto-park target (optional feature only)
//   PARK_STEP    auto-park ramp step (optional feature only)
//
// Ports:
//   clk          in   1   system clock
//   reset_n      in   1   asynchronous active-low reset
//   cmd_valid    in   1   command present
//   cmd_ready    out  1   scheduler can accept a command (high in IDLE)
//   cmd_target   in   17  requested control word
//   cmd_step     in   17  per-period increment, 0 means jump to target
//   abort        in   1   freeze the ramp at its current value
//   pwm_cw       out  17  control word to the PWM controller
//   busy         out  1   ramp in progress
//   ramp_done    out  1   one-cycle pulse when the ramp lands or is aborted
//   period_tick  out  1   one-cycle pulse on the last cycle of each period
//------------------------------------------------------------------------------
module pwm_ramp_scheduler #(
    parameter int PERIOD       = 100000,
    parameter int MIN_CW       = 0,
    parameter int MAX_CW       = 100000,
    parameter int RESET_CW     = 0,
    parameter int IDLE_TIMEOUT = 500,
    parameter int PARK_CW      = 0,
    parameter int PARK_STEP    = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [16:0] cmd_target,
    input  logic [16:0] cmd_step,
    input  logic        abort,
    output logic [16:0] pwm_cw,
    output logic        busy,
    output logic        ramp_done,
    output logic        period_tick
);

    // Period counter sizing; PERIOD >= 2 so at least one bit is needed.
    localparam int                CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);

    // Control-word limits as 17-bit constants.
    localparam logic [16:0] MIN_V   = 17'(MIN_CW);
    localparam logic [16:0] MAX_V   = 17'(MAX_CW);
    localparam logic [16:0] RESET_V = 17'(RESET_CW);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    // Registered state and outputs.
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [16:0]      r_cw;
    logic [16:0]      r_tgt;
    logic [16:0]      r_step;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    // Combinational helpers.
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;
    logic [16:0]      w_cmd_tgt;
    logic             w_up;
    logic [17:0]      w_diff;
    logic [17:0]      w_step_ext;
    logic             w_land;
    logic [17:0]      w_stepped;
    logic             w_unused_msb;
    logic             w_park_start;
    logic [16:0]      w_park_tgt;
    logic [16:0]      w_park_step;

    // Clamp a requested control word into the legal window.
    function automatic logic [16:0] f_clamp(input logic [16:0] v);
        if (v < MIN_V) begin
            return MIN_V;
        end else if (v > MAX_V) begin
            return MAX_V;
        end else begin
            return v;
        end
    endfunction

    // The counter wraps on PERIOD-1. period_tick is registered from the next
    // counter value so that it is high in exactly the cycle the counter holds
    // PERIOD-1, without a combinational path to the output.
    assign w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (w_cnt_next == CNT_LAST);
        end
    end

    // Handshake and target clamp.
    assign w_accept  = cmd_valid & r_ready;
    assign w_cmd_tgt = f_clamp(cmd_target);

    // Distance and next value are formed at 18 bits so that a large step can
    // never wrap past 0 or 2^17-1. A step only happens when the distance is
    // strictly larger than the step, so the stepped value always lies between
    // pwm_cw and the target and its top bit is always zero.
    assign w_up       = (r_tgt > r_cw);
    assign w_diff     = w_up ? ({1'b0, r_tgt} - {1'b0, r_cw})
                             : ({1'b0, r_cw} - {1'b0, r_tgt});
    assign w_step_ext = {1'b0, r_step};
    assign w_land     = (r_step == 17'd0) || (w_diff <= w_step_ext);
    assign w_stepped  = w_up ? ({1'b0, r_cw} + w_step_ext)
                             : ({1'b0, r_cw} - w_step_ext);
    assign w_unused_msb = w_stepped[17];

`ifdef PWM_SCHED_AUTO_PARK_EN
    // Idle counter: counts whole periods spent idle. It only needs to reach
    // IDLE_TIMEOUT-1 because it restarts as soon as the timeout is hit.
    localparam int                 IDLE_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [IDLE_W:0]    TIMEOUT_V = (IDLE_W + 1)'(IDLE_TIMEOUT);

    logic [IDLE_W-1:0] r_idle;
    logic              w_idle_hit;

    assign w_idle_hit = (({1'b0, r_idle} + (IDLE_W + 1)'(1)) >= TIMEOUT_V);

    // Parking starts on the tick that completes the idle timeout, unless a
    // command is being accepted in that same cycle or the output is already
    // parked.
    assign w_park_start = (r_state == S_IDLE) && r_tick && !w_accept &&
                          w_idle_hit && (r_cw != w_park_tgt);
    assign w_park_tgt   = f_clamp(17'(PARK_CW));
    assign w_park_step  = 17'(PARK_STEP);

    // Any accepted command or any time spent ramping restarts the idle count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle <= '0;
        end else if ((r_state != S_IDLE) || w_accept) begin
            r_idle <= '0;
        end else if (r_tick) begin
            r_idle <= w_idle_hit ? '0 : r_idle + IDLE_W'(1);
        end
    end
`else
    // Without auto-park the scheduler never starts a ramp on its own.
    logic w_unused_park;

    assign w_park_start  = 1'b0;
    assign w_park_tgt    = '0;
    assign w_park_step   = '0;
    assign w_unused_park = (IDLE_TIMEOUT != 0) ^ (PARK_CW != 0) ^ (PARK_STEP != 0);
`endif

    // Scheduler FSM. All handshake and status outputs are registered here so
    // they change together with the state. ramp_done defaults low every cycle
    // so it can only ever be a single-cycle pulse.
    //
    // A command accepted in a tick cycle is still in IDLE on that edge, so
    // the first step naturally lands on the following tick. abort is tested
    // before period_tick so that an abort on a tick freezes the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cw    <= RESET_V;
            r_tgt   <= RESET_V;
            r_step  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tgt  <= w_cmd_tgt;
                        r_step <= cmd_step;
                        if (w_cmd_tgt == r_cw) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RAMP;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end else if (w_park_start) begin
                        r_tgt   <= w_park_tgt;
                        r_step  <= w_park_step;
                        r_state <= S_RAMP;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RAMP: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_tick) begin
                        if (w_land) begin
                            r_cw    <= r_tgt;
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cw <= w_stepped[16:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = r_ready;
    assign busy        = r_busy;
    assign ramp_done   = r_done;
    assign period_tick = r_tick;
    assign pwm_cw      = r_cw;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
//------------------------------------------------------------------------------
// tb_pwm_ramp_scheduler
//
// Purpose: self-checking bench for pwm_ramp_scheduler with PERIOD=10,
// MIN_CW=100, MAX_CW=900, RESET_CW=100 (auto-park: IDLE_TIMEOUT=3,
// PARK_CW=100, PARK_STEP=200 when PWM_SCHED_AUTO_PARK_EN is defined).
// A behavioural reference model tracks the expected outputs using plain
// integer arithmetic; each scenario task compares the DUT against it and
// against fixed expected values.
//------------------------------------------------------------------------------
module tb_pwm_ramp_scheduler;

    localparam int PERIOD       = 10;
    localparam int MIN_CW       = 100;
    localparam int MAX_CW       = 900;
    localparam int RESET_CW     = 100;
    localparam int IDLE_TIMEOUT = 3;
    localparam int PARK_CW      = 100;
    localparam int PARK_STEP    = 200;

`ifdef PWM_SCHED_AUTO_PARK_EN
    localparam bit PARK_ON = 1'b1;
`else
    localparam bit PARK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [16:0] cmd_target;
    logic [16:0] cmd_step;
    logic        abort;
    logic [16:0] pwm_cw;
    logic        busy;
    logic        ramp_done;
    logic        period_tick;

    int checks = 0;
    int errors = 0;

    pwm_ramp_scheduler #(
        .PERIOD      (PERIOD),
        .MIN_CW      (MIN_CW),
        .MAX_CW      (MAX_CW),
        .RESET_CW    (RESET_CW),
        .IDLE_TIMEOUT(IDLE_TIMEOUT),
        .PARK_CW     (PARK_CW),
        .PARK_STEP   (PARK_STEP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .abort      (abort),
        .pwm_cw     (pwm_cw),
        .busy       (busy),
        .ramp_done  (ramp_done),
        .period_tick(period_tick)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Observed outputs packed as {pwm_cw, cmd_ready, busy, ramp_done, period_tick}.
    logic [20:0] w_act;
    assign w_act = {pwm_cw, cmd_ready, busy, ramp_done, period_tick};

    // Reference model state, kept as integers.
    int          m_cw;
    int          m_tgt;
    int          m_step;
    int          m_idle;
    int          m_edges;
    int          m_t;
    int          m_d;
    bit          m_ramp;
    bit          m_done;
    bit          m_tickSeen;
    bit          m_tickNow;
    logic [20:0] m_exp;

    function automatic int clampCw(input int v);
        if (v < MIN_CW) return MIN_CW;
        if (v > MAX_CW) return MAX_CW;
        return v;
    endfunction

    // Reference model. Time is counted in clock edges since reset; the tick
    // is high whenever the edge count sits on the last cycle of a period.
    // On every edge the model applies the command/abort/tick rules to the
    // values the inputs had just before that edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cw      = RESET_CW;
            m_tgt     = RESET_CW;
            m_step    = 0;
            m_idle    = 0;
            m_edges   = 0;
            m_ramp    = 1'b0;
            m_done    = 1'b0;
            m_tickNow = 1'b0;
        end else begin
            m_tickSeen = ((m_edges % PERIOD) == PERIOD - 1);
            m_done     = 1'b0;
            if (!m_ramp) begin
                if (cmd_valid) begin
                    m_t    = clampCw(int'(cmd_target));
                    m_idle = 0;
                    if (m_t == m_cw) begin
                        m_done = 1'b1;
                    end else begin
                        m_ramp = 1'b1;
                        m_tgt  = m_t;
                        m_step = int'(cmd_step);
                    end
                end else if (PARK_ON && m_tickSeen) begin
                    m_idle++;
                    if (m_idle >= IDLE_TIMEOUT) begin
                        m_idle = 0;
                        if (m_cw != PARK_CW) begin
                            m_ramp = 1'b1;
                            m_tgt  = clampCw(PARK_CW);
                            m_step = PARK_STEP;
                        end
                    end
                end
            end else begin
                m_idle = 0;
                if (abort) begin
                    m_ramp = 1'b0;
                    m_done = 1'b1;
                end else if (m_tickSeen) begin
                    m_d = (m_tgt > m_cw) ? m_tgt - m_cw : m_cw - m_tgt;
                    if (m_step == 0 || m_d <= m_step) begin
                        m_cw   = m_tgt;
                        m_ramp = 1'b0;
                        m_done = 1'b1;
                    end else if (m_tgt > m_cw) begin
                        m_cw = m_cw + m_step;
                    end else begin
                        m_cw = m_cw - m_step;
                    end
                end
            end
            m_edges++;
            m_tickNow = ((m_edges % PERIOD) == PERIOD - 1);
        end
        m_exp = {17'(m_cw), !m_ramp, m_ramp, m_done, m_tickNow};
    end

    // Present one command for a single cycle; the caller is responsible for
    // the scheduler being idle. Returns on the negedge after the accept edge.
    task automatic sendCmd(input int tgt, input int step);
        @(negedge clk);
        cmd_target = 17'(tgt);
        cmd_step   = 17'(step);
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Reset state, then the period tick cadence.
    task automatic test_reset();
        int lastTick;
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_step   = '0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (w_act !== {17'd100, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", w_act, {17'd100, 4'b1000});
        end
        reset_n  = 1'b1;
        lastTick = -1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL reset_model cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
            if (period_tick) begin
                if (lastTick >= 0) begin
                    checks++;
                    if (i - lastTick !== PERIOD) begin
                        errors++;
                        $display("[TB] FAIL tick_spacing: got %0d expected %0d", i - lastTick, PERIOD);
                    end
                end
                lastTick = i;
            end
        end
        checks++;
        if (lastTick < 0) begin
            errors++;
            $display("[TB] FAIL tick_seen: got none expected periodic tick");
        end
    endtask

    // 100 -> 400 in steps of 100, one step per tick.
    task automatic test_ramp_up();
        int seq[$];
        int lastCw;
        int doneCount;
        int tail;
        sendCmd(400, 100);
        lastCw    = 100;
        doneCount = 0;
        tail      = -1;
        for (int i = 0; i < 60 && tail != 0; i++) begin
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL ramp_up_model cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
            if (int'(pwm_cw) != lastCw) begin
                lastCw = int'(pwm_cw);
                seq.push_back(lastCw);
            end
            if (busy) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ramp_up_ready: got %b expected 0", cmd_ready);
                end
            end
            if (ramp_done) begin
                doneCount++;
                tail = 3;
            end
            if (tail > 0) tail--;
            @(negedge clk);
        end
        checks++;
        if (seq.size() != 3 || seq[0] != 200 || seq[1] != 300 || seq[2] != 400) begin
            errors++;
            $display("[TB] FAIL ramp_up_seq: got %p expected '{200, 300, 400}", seq);
        end
        checks++;
        if (doneCount != 1) begin
            errors++;
            $display("[TB] FAIL ramp_up_done: got %0d pulses expected 1", doneCount);
        end
    endtask

    // Out-of-range targets with step 0 are clamped and jumped to.
    task automatic test_clamp();
        int tgts[2] = '{2000, 50};
        int exps[2] = '{900, 100};
        bit got;
        for (int k = 0; k < 2; k++) begin
            sendCmd(tgts[k], 0);
            got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                checks++;
                if (w_act !== m_exp) begin
                    errors++;
                    $display("[TB] FAIL clamp_model cyc %0d: got %h expected %h", i, w_act, m_exp);
                end
                if (ramp_done) got = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (!got || pwm_cw !== 17'(exps[k])) begin
                errors++;
                $display("[TB] FAIL clamp_value tgt %0d: got %0d done=%b expected %0d", tgts[k], pwm_cw, got, exps[k]);
            end
        end
    endtask

    // 900 -> 100 step 300, aborted on the second step tick.
    task automatic test_abort();
        int  ticks;
        bit  got;
        bit  aborted;
        sendCmd(900, 0);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL abort_setup cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
            if (ramp_done) got = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (pwm_cw !== 17'd900) begin
            errors++;
            $display("[TB] FAIL abort_start: got %0d expected 900", pwm_cw);
        end
        sendCmd(100, 300);
        ticks   = 0;
        aborted = 1'b0;
        for (int i = 0; i < 40 && !aborted; i++) begin
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL abort_model cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
            if (period_tick) begin
                ticks++;
                if (ticks == 2) begin
                    abort   = 1'b1;
                    aborted = 1'b1;
                end
            end
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if ({pwm_cw, ramp_done, busy, cmd_ready} !== {17'd600, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL abort_result: got cw=%0d done=%b busy=%b rdy=%b expected cw=600 done=1 busy=0 rdy=1",
                     pwm_cw, ramp_done, busy, cmd_ready);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL abort_hold cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
        end
        checks++;
        if (pwm_cw !== 17'd600) begin
            errors++;
            $display("[TB] FAIL abort_frozen: got %0d expected 600", pwm_cw);
        end
        // abort while idle has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({pwm_cw, ramp_done, busy} !== {17'd600, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL abort_idle: got cw=%0d done=%b busy=%b expected cw=600 done=0 busy=0",
                     pwm_cw, ramp_done, busy);
        end
    endtask

    // 100 -> 450 step 100 lands without overshoot; a command held valid
    // during the ramp is only taken once the scheduler is idle again.
    task automatic test_back_to_back();
        int seq[$];
        int lastCw;
        int doneCount;
        bit dropNext;
        bit got;
        sendCmd(100, 0);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (ramp_done) got = 1'b1;
            @(negedge clk);
        end
        sendCmd(450, 100);
        cmd_target = 17'd700;
        cmd_step   = 17'd0;
        cmd_valid  = 1'b1;
        lastCw     = int'(pwm_cw);
        doneCount  = 0;
        dropNext   = 1'b0;
        for (int i = 0; i < 120 && doneCount < 2; i++) begin
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL b2b_model cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
            if (dropNext) begin
                cmd_valid = 1'b0;
                dropNext  = 1'b0;
            end
            if (int'(pwm_cw) != lastCw) begin
                lastCw = int'(pwm_cw);
                seq.push_back(lastCw);
            end
            if (ramp_done) doneCount++;
            if (busy && cmd_valid) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_holdoff: got ready=%b expected 0", cmd_ready);
                end
            end
            if (cmd_valid && cmd_ready) dropNext = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (seq.size() != 5 || seq[0] != 200 || seq[1] != 300 || seq[2] != 400 ||
            seq[3] != 450 || seq[4] != 700) begin
            errors++;
            $display("[TB] FAIL b2b_seq: got %p expected '{200, 300, 400, 450, 700}", seq);
        end
    endtask

    // Set 500, then sit idle: parks down to 100 with the feature, holds
    // at 500 without it.
    task automatic test_park();
        int seq[$];
        int lastCw;
        int doneCount;
        sendCmd(500, 0);
        lastCw    = int'(pwm_cw);
        doneCount = 0;
        for (int i = 0; i < 90; i++) begin
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL park_model cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
            if (int'(pwm_cw) != lastCw) begin
                lastCw = int'(pwm_cw);
                seq.push_back(lastCw);
            end
            if (ramp_done) doneCount++;
            @(negedge clk);
        end
        checks++;
        if (PARK_ON) begin
            if (seq.size() != 3 || seq[0] != 500 || seq[1] != 300 || seq[2] != 100 || doneCount != 2) begin
                errors++;
                $display("[TB] FAIL park_seq: got %p done=%0d expected '{500, 300, 100} done=2", seq, doneCount);
            end
        end else begin
            if (seq.size() != 1 || seq[0] != 500 || pwm_cw !== 17'd500 || doneCount != 1) begin
                errors++;
                $display("[TB] FAIL park_hold: got %p cw=%0d done=%0d expected '{500} cw=500 done=1",
                         seq, pwm_cw, doneCount);
            end
        end
    endtask

    // Reset in the middle of a ramp discards it.
    task automatic test_reset_midramp();
        sendCmd(900, 100);
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL midreset_model cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (w_act !== {17'd100, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_state: got %h expected %h", w_act, {17'd100, 4'b1000});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL midreset_after cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
        end
        checks++;
        if ({pwm_cw, busy} !== {17'd100, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_hold: got cw=%0d busy=%b expected cw=100 busy=0", pwm_cw, busy);
        end
    endtask

    // Random commands, steps and aborts checked cycle by cycle.
    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            checks++;
            if (w_act !== m_exp) begin
                errors++;
                $display("[TB] FAIL random_model cyc %0d: got %h expected %h", i, w_act, m_exp);
            end
            cmd_valid  = ($urandom_range(0, 15) == 0);
            cmd_target = ($urandom_range(0, 3) == 0) ? 17'($urandom) : 17'($urandom_range(0, 1000));
            cmd_step   = ($urandom_range(0, 3) == 0) ? 17'd0 : 17'($urandom_range(1, 400));
            abort      = ($urandom_range(0, 60) == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_ramp_up();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_park();
        test_reset_midramp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
